// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: MIPS execute stage with ID/EX pipeline register, valid/ready
// handshakes, flush, and an iterative MULT/MULTU unit feeding HI/LO.
// Optional feature macro: OVERFLOW_TRAP_EN (adds ovf_out, suppresses writes on
// signed overflow of add/addi/sub).
module ex_stage_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] PCPlus4_in,
  input  logic [XLEN-1:0] imm_signExt_in,
  input  logic [XLEN-1:0] imm_zeroExt_in,
  input  logic [RA_W-1:0] rt_addr_in,
  input  logic [RA_W-1:0] rd_addr_in,
  input  logic [4:0]      shamt_in,
  input  logic [25:0]     address_Jtype_in,
  input  logic [XLEN-1:0] rs_reg_in,
  input  logic [XLEN-1:0] rt_reg_in,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            RegDstD,
  input  logic [5:0]      ALUopD,
  input  logic [5:0]      ALUfunctD,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            RegWriteE,
  output logic            MemtoRegE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [5:0]      ALUopE,
  output logic [XLEN-1:0] WriteData_out,
  output logic [XLEN-1:0] PCPlus4_out,
  output logic [XLEN-1:0] PCBranch_out,
  output logic [RA_W-1:0] wb_addr_out,
  output logic [XLEN-1:0] ALUOut,
`ifdef OVERFLOW_TRAP_EN
  output logic            ovf_out,
`endif
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            state;
  logic              occ;
  logic [XLEN-1:0]   pc4_q, imm_s_q, imm_z_q, rs_q, rt_q, hi, lo, mcand, alu;
  logic [4:0]        shamt_q;
  logic [25:0]       addr_j_q;
  logic [5:0]        op_q, funct_q;
  logic [RA_W-1:0]   wb_addr_q;
  logic              reg_write_q, mem_to_reg_q, mem_write_q, branch_q, jump_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod, step_prod, mul_final;
  logic [XLEN:0]     step_sum;
  logic [XLEN-1:0]   add_res, sub_res, addi_res, rs_abs, rt_abs;
  logic              capture, is_mult_in, signed_in, ovf;

  assign out_valid  = occ & (state != S_MUL);
  assign in_ready   = ~flush & (~occ | (out_valid & out_ready));
  assign capture    = in_valid & in_ready;
  assign busy       = (state == S_MUL);
  assign is_mult_in = (ALUopD == 6'b000000) & (ALUfunctD[5:1] == 5'b01100);
  assign signed_in  = ~ALUfunctD[0];
  assign rs_abs     = (signed_in & rs_reg_in[XLEN-1]) ? -rs_reg_in : rs_reg_in;
  assign rt_abs     = (signed_in & rt_reg_in[XLEN-1]) ? -rt_reg_in : rt_reg_in;

  // Multiplier works on magnitudes: add mcand into the upper half when the
  // product LSB (current multiplier bit) is set, then shift right by one.
  assign step_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
  assign step_prod = {step_sum, prod[XLEN-1:1]};
  assign mul_final = neg_q ? -step_prod : step_prod;

  assign add_res  = rs_q + rt_q;
  assign sub_res  = rs_q - rt_q;
  assign addi_res = rs_q + imm_s_q;

`ifdef OVERFLOW_TRAP_EN
  // Signed overflow for trapping adds/subs of the held instruction
  always_comb begin
    ovf = 1'b0;
    if (op_q == 6'b000000 && funct_q == 6'b100000)
      ovf = (rs_q[XLEN-1] == rt_q[XLEN-1]) & (add_res[XLEN-1] != rs_q[XLEN-1]);
    else if (op_q == 6'b000000 && funct_q == 6'b100010)
      ovf = (rs_q[XLEN-1] != rt_q[XLEN-1]) & (sub_res[XLEN-1] != rs_q[XLEN-1]);
    else if (op_q == 6'b001000)
      ovf = (rs_q[XLEN-1] == imm_s_q[XLEN-1]) & (addi_res[XLEN-1] != rs_q[XLEN-1]);
  end
  assign ovf_out = ovf;
`else
  assign ovf = 1'b0;
`endif

  assign RegWriteE     = reg_write_q & (state != S_MUL) & ~ovf;
  assign MemWriteE     = mem_write_q & ~ovf;
  assign MemtoRegE     = mem_to_reg_q;
  assign BranchE       = branch_q;
  assign JumpE         = jump_q;
  assign ALUopE        = op_q;
  assign WriteData_out = rt_q;
  assign PCPlus4_out   = pc4_q;
  assign PCBranch_out  = pc4_q + (imm_s_q << 2);
  assign wb_addr_out   = wb_addr_q;
  assign ALUOut        = alu;

  // ALU result from the held operands
  always_comb begin
    alu = '0;
    case (op_q)
      6'b000000: begin
        case (funct_q)
          6'b000000: alu = rt_q << shamt_q;
          6'b000010: alu = rt_q >> shamt_q;
          6'b000011: alu = $unsigned($signed(rt_q) >>> shamt_q);
          6'b000100: alu = rt_q << rs_q[SHW-1:0];
          6'b000110: alu = rt_q >> rs_q[SHW-1:0];
          6'b000111: alu = $unsigned($signed(rt_q) >>> rs_q[SHW-1:0]);
          6'b001000: alu = rs_q;
          6'b010000: alu = hi;
          6'b010010: alu = lo;
          6'b011000, 6'b011001: alu = lo;
          6'b100000, 6'b100001: alu = add_res;
          6'b100010, 6'b100011: alu = sub_res;
          6'b100100: alu = rs_q & rt_q;
          6'b100101: alu = rs_q | rt_q;
          6'b100110: alu = rs_q ^ rt_q;
          6'b100111: alu = ~(rs_q | rt_q);
          6'b101010: alu = XLEN'($signed(rs_q) < $signed(rt_q));
          6'b101011: alu = XLEN'(rs_q < rt_q);
          default:   alu = '0;
        endcase
      end
      6'b000010, 6'b000011: alu = {pc4_q[XLEN-1:28], addr_j_q, 2'b00};
      6'b000100: alu = XLEN'(rs_q == rt_q);
      6'b000101: alu = XLEN'(rs_q != rt_q);
      6'b001000, 6'b001001: alu = addi_res;
      6'b001010: alu = XLEN'($signed(rs_q) < $signed(imm_s_q));
      6'b001011: alu = XLEN'(rs_q < imm_s_q);
      6'b001100: alu = rs_q & imm_z_q;
      6'b001101: alu = rs_q | imm_z_q;
      6'b001110: alu = rs_q ^ imm_z_q;
      6'b001111: alu = XLEN'({imm_z_q[15:0], 16'h0000});
      6'b100011, 6'b101011: alu = addi_res;
      default:   alu = '0;
    endcase
  end

  // Pipeline register, occupancy, multiplier FSM and HI/LO
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      occ <= 1'b0;
      pc4_q <= '0; imm_s_q <= '0; imm_z_q <= '0; rs_q <= '0; rt_q <= '0;
      shamt_q <= '0; addr_j_q <= '0; op_q <= '0; funct_q <= '0; wb_addr_q <= '0;
      reg_write_q <= 1'b0; mem_to_reg_q <= 1'b0; mem_write_q <= 1'b0;
      branch_q <= 1'b0; jump_q <= 1'b0;
      hi <= '0; lo <= '0; mcand <= '0; prod <= '0; neg_q <= 1'b0; cnt <= '0;
    end else if (flush) begin
      occ   <= 1'b0;
      state <= S_IDLE;
    end else if (capture) begin
      occ          <= 1'b1;
      pc4_q        <= PCPlus4_in;
      imm_s_q      <= imm_signExt_in;
      imm_z_q      <= imm_zeroExt_in;
      rs_q         <= rs_reg_in;
      rt_q         <= rt_reg_in;
      shamt_q      <= shamt_in;
      addr_j_q     <= address_Jtype_in;
      op_q         <= ALUopD;
      funct_q      <= ALUfunctD;
      wb_addr_q    <= (ALUopD == 6'b000011) ? '1 : (RegDstD ? rd_addr_in : rt_addr_in);
      reg_write_q  <= RegWriteD;
      mem_to_reg_q <= MemtoRegD;
      mem_write_q  <= MemWriteD;
      branch_q     <= BranchD;
      jump_q       <= JumpD;
      if (is_mult_in) begin
        state <= S_MUL;
        cnt   <= CW'(XLEN);
        mcand <= rs_abs;
        prod  <= {{XLEN{1'b0}}, rt_abs};
        neg_q <= signed_in & (rs_reg_in[XLEN-1] ^ rt_reg_in[XLEN-1]);
      end else begin
        state <= S_IDLE;
      end
    end else if (out_valid & out_ready) begin
      occ   <= 1'b0;
      state <= S_IDLE;
    end else if (state == S_MUL) begin
      prod <= step_prod;
      cnt  <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hi    <= mul_final[2*XLEN-1:XLEN];
        lo    <= mul_final[XLEN-1:0];
        state <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed testbench for ex_stage_pipe with hand-computed expected values.
module tb_ex_stage_pipe;

  logic        CLK = 1'b0;
  logic        RST, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] PCPlus4_in, imm_signExt_in, imm_zeroExt_in, rs_reg_in, rt_reg_in;
  logic [4:0]  rt_addr_in, rd_addr_in, shamt_in;
  logic [25:0] address_Jtype_in;
  logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD;
  logic [5:0]  ALUopD, ALUfunctD, ALUopE;
  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, busy;
  logic [31:0] WriteData_out, PCPlus4_out, PCBranch_out, ALUOut;
  logic [4:0]  wb_addr_out;
`ifdef OVERFLOW_TRAP_EN
  logic        ovf_out;
`endif

  int vecs = 0;
  int errs = 0;
  logic seen_valid;

  always #5 CLK = ~CLK;

  ex_stage_pipe #(.XLEN(32), .RA_W(5)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .PCPlus4_in(PCPlus4_in), .imm_signExt_in(imm_signExt_in), .imm_zeroExt_in(imm_zeroExt_in),
    .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in), .shamt_in(shamt_in),
    .address_Jtype_in(address_Jtype_in), .rs_reg_in(rs_reg_in), .rt_reg_in(rt_reg_in),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .RegDstD(RegDstD),
    .ALUopD(ALUopD), .ALUfunctD(ALUfunctD), .out_valid(out_valid), .out_ready(out_ready),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUopE(ALUopE), .WriteData_out(WriteData_out),
    .PCPlus4_out(PCPlus4_out), .PCBranch_out(PCBranch_out), .wb_addr_out(wb_addr_out),
    .ALUOut(ALUOut),
`ifdef OVERFLOW_TRAP_EN
    .ovf_out(ovf_out),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; PCPlus4_in = '0; imm_signExt_in = '0; imm_zeroExt_in = '0;
    rs_reg_in = '0; rt_reg_in = '0; rt_addr_in = '0; rd_addr_in = '0; shamt_in = '0;
    address_Jtype_in = '0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0;
    BranchD = 0; JumpD = 0; RegDstD = 0; ALUopD = '0; ALUfunctD = '0;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    clear_in();
    in_valid = 1'b1; ALUopD = op; ALUfunctD = fn; rs_reg_in = rs; rt_reg_in = rt;
  endtask

  initial begin
    clear_in();
    flush = 1'b0; out_ready = 1'b1; RST = 1'b1;
    seen_valid = 1'b0;

    // Reset
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_aluout", ALUOut, 0);
    chk("rst_wb_addr", wb_addr_out, 0);
    chk("rst_pcbranch", PCBranch_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regwrite", RegWriteE, 0);

    // add 5+7 -> rd 3
    instr(6'b000000, 6'b100000, 32'd5, 32'd7);
    RegDstD = 1; rd_addr_in = 5'd3; rt_addr_in = 5'd9; RegWriteD = 1;
    PCPlus4_in = 32'h100; imm_signExt_in = 32'd4;
    tick();
    clear_in();
    chk("add_valid", out_valid, 1);
    chk("add_result", ALUOut, 12);
    chk("add_wb_addr", wb_addr_out, 3);
    chk("add_regwrite", RegWriteE, 1);
    chk("add_pcbranch", PCBranch_out, 32'h110);
    chk("add_in_ready", in_ready, 1);
    tick();
    chk("add_drained", out_valid, 0);

    // jal: target and link register
    instr(6'b000011, 6'b000000, 32'd0, 32'd0);
    PCPlus4_in = 32'hA000_0004; address_Jtype_in = 26'h1; rt_addr_in = 5'd4;
    tick();
    instr(6'b000000, 6'b000011, 32'd0, 32'h8000_0000);  // sra by 4, back-to-back
    shamt_in = 5'd4;
    chk("jal_target", ALUOut, 32'hA000_0004);
    chk("jal_wb_addr", wb_addr_out, 5'd31);
    tick();
    instr(6'b000100, 6'b000000, 32'd5, 32'd5);          // beq equal
    chk("sra_result", ALUOut, 32'hF800_0000);
    tick();
    clear_in();
    chk("beq_result", ALUOut, 1);
    tick();

    // MULT -3 * 4
    instr(6'b000000, 6'b011000, 32'hFFFF_FFFD, 32'd4);
    tick();
    clear_in();
    chk("mult_busy_c1", busy, 1);
    chk("mult_nvalid_c1", out_valid, 0);
    chk("mult_in_ready_c1", in_ready, 0);
    for (int i = 0; i < 31; i++) tick();
    chk("mult_busy_c32", busy, 1);
    chk("mult_nvalid_c32", out_valid, 0);
    tick();
    chk("mult_valid_c33", out_valid, 1);
    chk("mult_busy_c33", busy, 0);
    chk("mult_lo", ALUOut, 32'hFFFF_FFF4);
    chk("mult_regwrite", RegWriteE, 0);
    instr(6'b000000, 6'b010000, 32'd0, 32'd0);          // mfhi
    tick();
    instr(6'b000000, 6'b010010, 32'd0, 32'd0);          // mflo
    chk("mfhi", ALUOut, 32'hFFFF_FFFF);
    tick();
    clear_in();
    chk("mflo", ALUOut, 32'hFFFF_FFF4);
    tick();

    // Back-pressure on slt 1<2
    out_ready = 1'b0;
    instr(6'b000000, 6'b101010, 32'd1, 32'd2);
    tick();
    instr(6'b000000, 6'b100010, 32'd10, 32'd3);         // sub waiting upstream
    for (int i = 0; i < 5; i++) begin
      chk("bp_slt_result", ALUOut, 1);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    clear_in();
    chk("bp_sub_result", ALUOut, 7);
    chk("bp_sub_valid", out_valid, 1);
    tick();

    // Flush during MULTU at MUL cycle 10; a capture attempt in the same cycle
    instr(6'b000000, 6'b011001, 32'hFFFF_FFFF, 32'd2);
    tick();
    clear_in();
    for (int i = 0; i < 9; i++) tick();
    chk("fl_busy_c10", busy, 1);
    flush = 1'b1;
    instr(6'b000000, 6'b100000, 32'd1, 32'd1);
    #1;
    chk("fl_in_ready_masked", in_ready, 0);
    tick();
    flush = 1'b0;
    clear_in();
    #1;
    chk("fl_in_ready_after", in_ready, 1);
    chk("fl_busy_after", busy, 0);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen_valid = 1'b1;
      tick();
    end
    chk("fl_never_valid", seen_valid, 0);
    instr(6'b000000, 6'b010000, 32'd0, 32'd0);
    tick();
    instr(6'b000000, 6'b010010, 32'd0, 32'd0);
    chk("fl_hi_kept", ALUOut, 32'hFFFF_FFFF);
    tick();
    clear_in();
    chk("fl_lo_kept", ALUOut, 32'hFFFF_FFF4);
    tick();

    // Signed overflow on add
    instr(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1);
    RegWriteD = 1; RegDstD = 1; rd_addr_in = 5'd8;
    tick();
    clear_in();
`ifdef OVERFLOW_TRAP_EN
    chk("ovf_flag", ovf_out, 1);
    chk("ovf_regwrite", RegWriteE, 0);
`else
    chk("wrap_result", ALUOut, 32'h8000_0000);
    chk("wrap_regwrite", RegWriteE, 1);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
